// File: rtl/regfile.sv
// Register file: 2^ADDR_W x DATA_W, one write port, two combinational read ports.
// Register 0 reads as zero; optional same-cycle write-to-read bypass.

module regfile_decoder #(
    parameter int N = 5
) (
    input  logic [N-1:0]      code,
    output logic [2**N-1:0]   onehot
);

    always_comb begin
        onehot       = '0;
        onehot[code] = 1'b1;
    end

endmodule

module regfile #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter bit BYPASS = 1'b0
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB
);

    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0]   wr_onehot;
    logic [NREG-1:1]   load_en;
    logic [DATA_W-1:0] mem [1:NREG-1];
    logic              wr_nonzero;
    logic [DATA_W-1:0] stored_a;
    logic [DATA_W-1:0] stored_b;
    logic              hit_a;
    logic              hit_b;

    regfile_decoder #(.N(ADDR_W)) u_wr_dec (
        .code   (ctrl_writeReg),
        .onehot (wr_onehot)
    );

    // Bit 0 of the decode has no register behind it; it marks a discarded write.
    assign wr_nonzero = ~wr_onehot[0];
    assign load_en    = wr_onehot[NREG-1:1] & {(NREG-1){ctrl_writeEnable}};

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 1; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (load_en[i]) begin
                    mem[i] <= data_writeReg;
                end
            end
        end
    end

    // AND-OR read network; address 0 matches nothing and so yields zero.
    always_comb begin
        stored_a = '0;
        stored_b = '0;
        for (int i = 1; i < NREG; i++) begin
            if (ctrl_readRegA == ADDR_W'(i)) begin
                stored_a = stored_a | mem[i];
            end
            if (ctrl_readRegB == ADDR_W'(i)) begin
                stored_b = stored_b | mem[i];
            end
        end
    end

    assign hit_a = BYPASS && ctrl_writeEnable && wr_nonzero
                   && (ctrl_readRegA == ctrl_writeReg);
    assign hit_b = BYPASS && ctrl_writeEnable && wr_nonzero
                   && (ctrl_readRegB == ctrl_writeReg);

    always_comb begin
        data_readRegA = '0;
        data_readRegB = '0;
        if (ctrl_reset_n) begin
            data_readRegA = hit_a ? data_writeReg : stored_a;
            data_readRegB = hit_b ? data_writeReg : stored_b;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: one instance without bypass, one with bypass,
// driven from the same stimulus.

module tb_regfile;

    logic        clock;
    logic        ctrl_reset_n;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] rd_a0, rd_b0, rd_a1, rd_b1;

    int n_pass  = 0;
    int n_total = 0;

    regfile #(.ADDR_W(5), .DATA_W(32), .BYPASS(1'b0)) u_dut0 (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (rd_a0),
        .data_readRegB    (rd_b0)
    );

    regfile #(.ADDR_W(5), .DATA_W(32), .BYPASS(1'b1)) u_dut1 (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (rd_a1),
        .data_readRegB    (rd_b1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, need 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = addr;
        data_writeReg    = data;
        tick();
        ctrl_writeEnable = 1'b0;
    endtask

    function automatic logic [31:0] sweep_val(input int i);
        return (i == 0) ? 32'h0 : 32'(i) * 32'h01010101;
    endfunction

    initial begin
        ctrl_reset_n     = 1'b0;
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd5;
        data_writeReg    = 32'hDEADBEEF;
        ctrl_readRegA    = 5'd5;
        ctrl_readRegB    = 5'd5;
        #1;
        check("rst_async_a0", rd_a0, 32'h0);
        check("rst_async_a1", rd_a1, 32'h0);

        // Two edges with a write pending while held in reset: must be ignored.
        tick();
        tick();
        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(31 - i);
            #1;
            check("rst_a0", rd_a0, 32'h0);
            check("rst_b0", rd_b0, 32'h0);
            check("rst_a1", rd_a1, 32'h0);
            check("rst_b1", rd_b1, 32'h0);
        end
        ctrl_writeEnable = 1'b0;
        #2;
        ctrl_reset_n = 1'b1;

        write_reg(5'd5, 32'hDEADBEEF);
        ctrl_readRegA = 5'd5;
        #1;
        check("r5_a0", rd_a0, 32'hDEADBEEF);
        check("r5_a1", rd_a1, 32'hDEADBEEF);

        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'hFFFFFFFF;
        ctrl_readRegA    = 5'd0;
        ctrl_readRegB    = 5'd0;
        #1;
        check("r0_byp_a1", rd_a1, 32'h0);
        check("r0_byp_b1", rd_b1, 32'h0);
        tick();
        ctrl_writeEnable = 1'b0;
        #1;
        check("r0_a0", rd_a0, 32'h0);
        check("r0_b0", rd_b0, 32'h0);
        check("r0_a1", rd_a1, 32'h0);
        check("r0_b1", rd_b1, 32'h0);

        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), sweep_val(i));
        end
        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = 5'(i);
            ctrl_readRegB = 5'(31 - i);
            #1;
            check("sweep_a0", rd_a0, sweep_val(i));
            check("sweep_b0", rd_b0, sweep_val(31 - i));
            check("sweep_a1", rd_a1, sweep_val(i));
            check("sweep_b1", rd_b1, sweep_val(31 - i));
        end

        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd7;
        data_writeReg    = 32'h12345678;
        ctrl_readRegA    = 5'd7;
        tick();
        tick();
        tick();
        check("we_low_a0", rd_a0, 32'h07070707);
        check("we_low_a1", rd_a1, 32'h07070707);

        write_reg(5'd9, 32'hAAAA0000);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd9;
        data_writeReg    = 32'h5555FFFF;
        ctrl_readRegA    = 5'd9;
        ctrl_readRegB    = 5'd8;
        #1;
        check("r9_pre_a0", rd_a0, 32'hAAAA0000);
        check("r9_byp_a1", rd_a1, 32'h5555FFFF);
        check("r8_nobyp_b1", rd_b1, 32'h08080808);
        tick();
        ctrl_writeEnable = 1'b0;
        #1;
        check("r9_post_a0", rd_a0, 32'h5555FFFF);
        check("r9_post_a1", rd_a1, 32'h5555FFFF);

        write_reg(5'd3, 32'h0000BEEF);
        ctrl_readRegA = 5'd3;
        ctrl_readRegB = 5'd31;
        #1;
        check("r3_pre_a0", rd_a0, 32'h0000BEEF);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd3;
        data_writeReg    = 32'h0000CAFE;
        #1;
        check("r3_byp_a1", rd_a1, 32'h0000CAFE);
        ctrl_reset_n = 1'b0;
        #1;
        check("midrst_a0", rd_a0, 32'h0);
        check("midrst_a1", rd_a1, 32'h0);
        check("midrst_b0", rd_b0, 32'h0);
        tick();
        check("midrst_edge_a0", rd_a0, 32'h0);
        check("midrst_edge_a1", rd_a1, 32'h0);
        ctrl_writeEnable = 1'b0;
        #2;
        ctrl_reset_n = 1'b1;
        #1;
        check("after_rst_r3_a0", rd_a0, 32'h0);
        check("after_rst_r31_b0", rd_b0, 32'h0);
        check("after_rst_r3_a1", rd_a1, 32'h0);

        write_reg(5'd3, 32'h0000CAFE);
        #1;
        check("post_rst_wr_a0", rd_a0, 32'h0000CAFE);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
